psum_ctrl: RTL
==============

# psum_ctrl

Sequencing controller for the three-stage psum adder tree and its psum FIFO. It accepts PE-array psum beats and tracks the current element and input-channel pass. It issues psum FIFO reads aligned to the adder's FIFO-operand stage, and forces the FIFO operand to zero on the first pass. It routes each adder result back into the FIFO on intermediate passes, or to the output on the last pass.

## Interface

Parameters:
- DATA_WIDTH, 25, psum width (informational; the controller carries no data).
- FIFO_DEPTH, 64, psum FIFO entries; the maximum legal row length.
- LEN_W, 7, width of cfg_row_len; must hold FIFO_DEPTH.
- PASS_W, 8, width of cfg_num_pass.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  start pulse; sampled only in IDLE.
- cfg_row_len  in  LEN_W  psums per pass; latched on accepted start.
- cfg_num_pass  in  PASS_W  passes to accumulate; latched on accepted start.
- busy  out  1  high from the accepted start until DONE.
- done  out  1  one-cycle pulse at the end of a job.
- cfg_err  out  1  one-cycle pulse when a start is rejected.
- pe_valid  in  1  PE array presents pe0..pe3 data to the adder this cycle.
- pe_ready  out  1  controller accepts the beat; a beat moves on pe_valid && pe_ready.
- fifo_clr  out  1  one-cycle psum FIFO flush on accepted start.
- fifo_rd_en  out  1  psum FIFO pop; the FIFO has a registered read, so data is valid one cycle after the pop.
- fifo_empty  in  1  psum FIFO empty.
- fifo_afull  in  1  psum FIFO has 3 or fewer free entries.
- fifo_zero  out  1  datapath mux select: drive fifo_data = 0 into the adder.
- fifo_wr_en  out  1  push the adder result into the psum FIFO.
- out_valid  out  1  adder result is final (last pass).
- out_last  out  1  with out_valid: final element of the job.

## Operation

- States: IDLE, RUN, DRAIN, DONE.
- IDLE, cfg_start=1, transitions:
  - If cfg_row_len == 0 or cfg_row_len > FIFO_DEPTH: pulse cfg_err, stay IDLE.
  - Otherwise latch the config and pulse fifo_clr. A cfg_num_pass of 0 is latched as 1. Clear elem_cnt and pass_cnt, then go to RUN.
- cfg_start is ignored outside IDLE.
- RUN, pe_ready = !first_pass_stall && !wr_stall, where:
  - first_pass_stall = (pass_cnt != 0) && fifo_empty.
  - wr_stall = (pass_cnt != last) && fifo_afull.
  - The fifo_afull margin of 3 covers the in-flight adder beats.
- Accepted beat:
  - elem_cnt increments.
  - At row_len-1, elem_cnt wraps to 0 and pass_cnt increments.
  - On the final beat of the final pass, go to DRAIN.
- Each accepted beat carries a 3-bit tag {wr, out, last} down a 3-deep valid shift register:
  - wr = !last_pass.
  - out = last_pass.
  - last = final beat.
- DRAIN: wait until the shift register is empty, then go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Pass boundary: no bubble. The next pass reads FIFO entries in write order. If row_len ≤ 3, reads may stall on fifo_empty until the previous pass's writes land.
- Asserting rst at any time resets all state, counters and the shift register. In-flight beats are discarded and no write or output is issued for them.

## Timing

- Reset values: state=IDLE; all outputs 0 except pe_ready=0 and fifo_zero=0.
- For a beat accepted at cycle t:
  - fifo_rd_en=1 at t+1 if pass_cnt != 0.
  - fifo_zero=1 at t+2 if first pass.
  - fifo_wr_en or out_valid at t+3, coincident with the valid adder output.
- The pop at t+1 is committed at acceptance. fifo_empty is checked at t, and no other consumer pops the FIFO.
- done asserts 4 cycles after the final accepted beat (3 pipeline cycles plus DONE).
- busy and pe_ready deassert in DRAIN.
- fifo_wr_en and out_valid are never high in the same cycle.
- Back-to-back jobs: a start is accepted the cycle after done.

## Test plan

- row_len=4, num_pass=1, pe_valid held high:
  - fifo_zero high for 4 cycles starting at t+2.
  - 4 out_valid pulses at t+3..t+6, out_last on the 4th.
  - No FIFO reads or writes; done 4 cycles after the last beat.
- row_len=8, num_pass=3:
  - 16 fifo_wr_en, 16 fifo_rd_en, 8 out_valid.
  - fifo_rd_en only in passes 1–2.
  - With a reference FIFO model plus adder, outputs equal the sum over 3 passes.
- row_len=2, num_pass=2: pe_ready drops at the pass boundary until the first write lands; no underflow and correct sums.
- fifo_afull forced high mid-pass-0: pe_ready=0 while high. In-flight beats (at most 3) still write; no overflow.
- cfg_row_len=0 or FIFO_DEPTH+1: cfg_err pulse, busy stays 0. A start during RUN is ignored.
- rst asserted 1 cycle after the final beat: no further fifo_wr_en, out_valid or done. The next job runs cleanly.

Source files
------------

// File: rtl/psum_ctrl.sv
// Sequencing controller for the 3-stage psum adder tree and its psum FIFO.
// Tracks element/pass position and times FIFO pop, zero-operand, write-back and output strobes.
module psum_ctrl #(
    parameter int DATA_WIDTH = 25,
    parameter int FIFO_DEPTH = 64,
    parameter int LEN_W      = 7,
    parameter int PASS_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [LEN_W-1:0]  cfg_row_len,
    input  logic [PASS_W-1:0] cfg_num_pass,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    input  logic              pe_valid,
    output logic              pe_ready,
    output logic              fifo_clr,
    output logic              fifo_rd_en,
    input  logic              fifo_empty,
    input  logic              fifo_afull,
    output logic              fifo_zero,
    output logic              fifo_wr_en,
    output logic              out_valid,
    output logic              out_last
);

    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int T_LAST = 0;
    localparam int T_OUT  = 1;
    localparam int T_WR   = 2;
    localparam int T_ZERO = 3;
    localparam int T_RD   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  row_len_q, row_len_d;
    logic [LEN_W-1:0]  elem_cnt_q, elem_cnt_d;
    logic [PASS_W-1:0] num_pass_q, num_pass_d;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [4:0]        tag1_q, tag1_d;
    logic [4:0]        tag2_q, tag2_d;
    logic [4:0]        tag3_q, tag3_d;
    logic              cfg_err_q, cfg_err_d;
    logic              fifo_clr_q, fifo_clr_d;

    logic first_pass;
    logic last_pass;
    logic final_elem;
    logic first_pass_stall;
    logic wr_stall;
    logic cfg_bad;
    logic accept;

    // Position decode and stall conditions.
    always_comb begin
        first_pass = (pass_cnt_q == PASS_W'(0));
        last_pass  = (pass_cnt_q == (num_pass_q - PASS_W'(1)));
        final_elem = (elem_cnt_q == (row_len_q - LEN_W'(1)));
        // The last entry may already be leaving via this cycle's pop with no write landing to replace it.
        first_pass_stall = !first_pass &&
                           (fifo_empty ||
                            (tag1_q[T_RD] && !tag3_q[T_WR] && (occ_q == OCC_W'(1))));
        wr_stall   = !last_pass && fifo_afull;
        cfg_bad    = (cfg_row_len == LEN_W'(0)) || (cfg_row_len > LEN_W'(FIFO_DEPTH));
    end

    // Next-state, counters and beat-tag pipeline.
    always_comb begin
        state_d    = state_q;
        row_len_d  = row_len_q;
        num_pass_d = num_pass_q;
        elem_cnt_d = elem_cnt_q;
        pass_cnt_d = pass_cnt_q;
        occ_d      = occ_q + OCC_W'(tag3_q[T_WR]) - OCC_W'(tag1_q[T_RD]);
        cfg_err_d  = 1'b0;
        fifo_clr_d = 1'b0;
        pe_ready   = 1'b0;
        accept     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start && cfg_bad) begin
                    cfg_err_d = 1'b1;
                end else if (cfg_start) begin
                    row_len_d  = cfg_row_len;
                    num_pass_d = (cfg_num_pass == PASS_W'(0)) ? PASS_W'(1) : cfg_num_pass;
                    elem_cnt_d = LEN_W'(0);
                    pass_cnt_d = PASS_W'(0);
                    occ_d      = OCC_W'(0);
                    fifo_clr_d = 1'b1;
                    state_d    = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                pe_ready = !first_pass_stall && !wr_stall;
                accept   = pe_valid && pe_ready;
                if (accept && final_elem) begin
                    elem_cnt_d = LEN_W'(0);
                    pass_cnt_d = pass_cnt_q + PASS_W'(1);
                    state_d    = last_pass ? S_DRAIN : S_RUN;
                end else if (accept) begin
                    elem_cnt_d = elem_cnt_q + LEN_W'(1);
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // Stage 3 drains on its own this cycle, so only stages 1-2 gate the exit.
                if ((tag1_q == 5'b0) && (tag2_q == 5'b0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        tag1_d = accept ? {!first_pass, first_pass, !last_pass, last_pass, last_pass && final_elem}
                        : 5'b0;
        tag2_d = tag1_q;
        tag3_d = tag2_q;
    end

    // State, config and pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_len_q  <= LEN_W'(0);
            num_pass_q <= PASS_W'(0);
            elem_cnt_q <= LEN_W'(0);
            pass_cnt_q <= PASS_W'(0);
            occ_q      <= OCC_W'(0);
            tag1_q     <= 5'b0;
            tag2_q     <= 5'b0;
            tag3_q     <= 5'b0;
            cfg_err_q  <= 1'b0;
            fifo_clr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_len_q  <= row_len_d;
            num_pass_q <= num_pass_d;
            elem_cnt_q <= elem_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            occ_q      <= occ_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag2_d;
            tag3_q     <= tag3_d;
            cfg_err_q  <= cfg_err_d;
            fifo_clr_q <= fifo_clr_d;
        end
    end

    // Output decode straight from flops.
    always_comb begin
        busy       = (state_q == S_RUN);
        done       = (state_q == S_DONE);
        cfg_err    = cfg_err_q;
        fifo_clr   = fifo_clr_q;
        fifo_rd_en = tag1_q[T_RD];
        fifo_zero  = tag2_q[T_ZERO];
        fifo_wr_en = tag3_q[T_WR];
        out_valid  = tag3_q[T_OUT];
        out_last   = tag3_q[T_LAST];
    end

endmodule
